// File: rtl/instr_mem_param.sv
// -----------------------------------------------------------------------------
// instr_mem_param
//
// Parametrised instruction memory sitting between the fetch stage (read side)
// and the program loader (write side). After every reset a hardware sequencer
// walks the whole array and writes an init value into each word. Only then does
// the read port start accepting requests.
//
// Configuration macro:
//   IMEM_BOOT_PRELOAD_EN  When defined, the init sequence writes a fixed boot
//                         program into words 0..4 (zero-extended to DATA_W) and
//                         0 everywhere else. When undefined, every word is
//                         cleared to 0. In both builds init takes DEPTH cycles.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   init_busy  high while the init sequencer is running
//   rd_req     fetch request
//   rd_addr    fetch word address
//   rd_ready   request is accepted this cycle if rd_req=1
//   rd_stall   consumer cannot take rd_data this cycle
//   rd_valid   rd_data/rd_err are valid
//   rd_data    fetched word (registered, one cycle after accept)
//   rd_err     fetched address was >= DEPTH
//   wr_en      loader write strobe
//   wr_addr    loader write address
//   wr_data    loader write data
//   wr_drop    one-cycle pulse: write was discarded (init running or bad addr)
// -----------------------------------------------------------------------------
module instr_mem_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  input  logic              rd_stall,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_drop
);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  // DEPTH needs one more bit than an address for the range compares, since an
  // address can never hold the value DEPTH itself when DEPTH is a power of 2.
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] init_ptr;
  logic [DATA_W-1:0] init_value;
  logic [DATA_W-1:0] mem [DEPTH];

  logic rd_in_range;
  logic wr_in_range;
  logic rd_accept;
  logic rd_hold;

`ifdef IMEM_BOOT_PRELOAD_EN
  function automatic logic [DATA_W-1:0] boot_word(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] w;
    w = '0;
    case (int'(idx))
      1:       w = DATA_W'(32'h5441_0003);
      2:       w = DATA_W'(32'h5101_0001);
      3:       w = DATA_W'(32'h9064_0800);
      4:       w = DATA_W'(32'hB148_0800);
      default: w = '0;
    endcase
    return w;
  endfunction

  assign init_value = boot_word(init_ptr);
`else
  assign init_value = '0;
`endif

  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);

  assign init_busy = (state == S_INIT);
  // A stalled, still-valid result blocks new requests so it is not overwritten.
  assign rd_hold   = rd_valid && rd_stall;
  assign rd_ready  = (state == S_READY) && !rd_hold;
  assign rd_accept = rd_req && rd_ready;

  // Sequencer and drop reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      init_ptr <= '0;
      wr_drop  <= 1'b0;
    end else begin
      wr_drop <= wr_en && ((state == S_INIT) || !wr_in_range);
      if (state == S_INIT) begin
        init_ptr <= init_ptr + ADDR_W'(1);
        if (init_ptr == LAST_PTR) begin
          state <= S_READY;
        end
      end
    end
  end

  // Single write port shared by the init sequencer and the loader. No reset on
  // the array itself; contents are left alone during the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT) begin
        mem[init_ptr] <= init_value;
      end else if (wr_en && wr_in_range) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  // Registered read port. Read-before-write falls out of the nonblocking
  // semantics: a same-cycle write to the same word is seen by the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else if (rd_hold) begin
      rd_valid <= rd_valid;
      rd_data  <= rd_data;
      rd_err   <= rd_err;
    end else if (rd_accept) begin
      rd_valid <= 1'b1;
      if (rd_in_range) begin
        rd_data <= mem[rd_addr];
        rd_err  <= 1'b0;
      end else begin
        rd_data <= '0;
        rd_err  <= 1'b1;
      end
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_param.sv
module tb_instr_mem_param;

  logic        clk;
  logic        rst;
  logic        rd_req;
  logic [2:0]  rd_addr;
  logic        rd_stall;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;

  // Index 0: DEPTH=8 instance, index 1: DEPTH=6 instance (same stimulus).
  logic        init_busy [2];
  logic        rd_ready  [2];
  logic        rd_valid  [2];
  logic [31:0] rd_data   [2];
  logic        rd_err    [2];
  logic        wr_drop   [2];

  int dep [2] = '{8, 6};

  // Behavioural reference: array contents, remaining init cycles, output regs.
  logic [31:0] m_mem   [2][8];
  int          m_left  [2];
  logic        m_valid [2];
  logic [31:0] m_data  [2];
  logic        m_err   [2];
  logic        m_drop  [2];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  instr_mem_param #(.DATA_W(32), .DEPTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy[0]),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready[0]),
    .rd_stall  (rd_stall),
    .rd_valid  (rd_valid[0]),
    .rd_data   (rd_data[0]),
    .rd_err    (rd_err[0]),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_drop   (wr_drop[0])
  );

  instr_mem_param #(.DATA_W(32), .DEPTH(6)) u_dut6 (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy[1]),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready[1]),
    .rd_stall  (rd_stall),
    .rd_valid  (rd_valid[1]),
    .rd_data   (rd_data[1]),
    .rd_err    (rd_err[1]),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_drop   (wr_drop[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] boot(input int k);
`ifdef IMEM_BOOT_PRELOAD_EN
    case (k)
      1:       return 32'h5441_0003;
      2:       return 32'h5101_0001;
      3:       return 32'h9064_0800;
      4:       return 32'hB148_0800;
      default: return 32'h0;
    endcase
`else
    return (k < 0) ? 32'hFFFF_FFFF : 32'h0;
`endif
  endfunction

  task automatic check(input string tag, input int i, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s depth=%0d observed=%h expected=%h", tag, dep[i], obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs before the edge,
  // advance the model across the edge, check registered outputs after it.
  task automatic cyc(input logic r, input logic rq, input logic [2:0] ra,
                     input logic st, input logic we, input logic [2:0] wa,
                     input logic [31:0] wd);
    rst = r; rd_req = rq; rd_addr = ra; rd_stall = st;
    wr_en = we; wr_addr = wa; wr_data = wd;
    #1;
    if (!r) begin
      for (int i = 0; i < 2; i++) begin
        check("init_busy", i, 32'(init_busy[i]), 32'(m_left[i] != 0));
        check("rd_ready", i, 32'(rd_ready[i]),
              32'((m_left[i] == 0) && !(m_valid[i] && st)));
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_left[i]  = dep[i];
        m_valid[i] = 1'b0;
        m_data[i]  = 32'h0;
        m_err[i]   = 1'b0;
        m_drop[i]  = 1'b0;
      end else begin
        logic rdy;
        rdy = (m_left[i] == 0);
        if (!(m_valid[i] && st)) begin
          if (rq && rdy) begin
            m_valid[i] = 1'b1;
            if (int'(ra) < dep[i]) begin
              m_data[i] = m_mem[i][ra];
              m_err[i]  = 1'b0;
            end else begin
              m_data[i] = 32'h0;
              m_err[i]  = 1'b1;
            end
          end else begin
            m_valid[i] = 1'b0;
          end
        end
        m_drop[i] = we && (!rdy || int'(wa) >= dep[i]);
        if (!rdy) begin
          int idx;
          idx = dep[i] - m_left[i];
          m_mem[i][idx] = boot(idx);
          m_left[i]--;
        end else if (we && int'(wa) < dep[i]) begin
          m_mem[i][wa] = wd;
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rd_valid", i, 32'(rd_valid[i]), 32'(m_valid[i]));
      check("wr_drop", i, 32'(wr_drop[i]), 32'(m_drop[i]));
      if (r || m_valid[i]) begin
        check("rd_data", i, rd_data[i], m_data[i]);
        check("rd_err", i, 32'(rd_err[i]), 32'(m_err[i]));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rd_req = 1'b0; rd_addr = '0; rd_stall = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0; m_valid[i] = 1'b0; m_data[i] = '0; m_err[i] = 1'b0; m_drop[i] = 1'b0;
      for (int a = 0; a < 8; a++) m_mem[i][a] = 32'hXXXX_XXXX;
    end

    // Reset two cycles, then the init phase (a write during init must drop).
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 3'(k), 0, (k == 2), 3'd1, 32'hCAFE_0001);
    end
    check("init_done8", 0, 32'(init_busy[0]), 32'd0);

    // Read back every address, back-to-back.
    for (int k = 0; k < 8; k++) cyc(0, 1, 3'(k), 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Write then read.
    cyc(0, 0, 0, 0, 1, 3'd6, 32'hDEAD_BEEF);
    cyc(0, 1, 3'd6, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Same-cycle collision: read-first, then the new word.
    cyc(0, 0, 0, 0, 1, 3'd2, 32'h1111_1111);
    cyc(0, 1, 3'd2, 0, 1, 3'd2, 32'h2222_2222);
    cyc(0, 1, 3'd2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Stall: accept addr 1, stall 3 cycles with the address wandering.
    cyc(0, 1, 3'd1, 0, 0, 0, 0);
    cyc(0, 1, 3'd5, 1, 0, 0, 0);
    cyc(0, 1, 3'd3, 1, 0, 0, 0);
    cyc(0, 1, 3'd0, 1, 0, 0, 0);
    cyc(0, 1, 3'd4, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Out of range on the DEPTH=6 instance.
    cyc(0, 1, 3'd7, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 3'd6, 32'h0BAD_0BAD);
    cyc(0, 1, 3'd6, 0, 1, 3'd7, 32'h1234_5678);
    cyc(0, 1, 3'd7, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Randomised traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      logic r, rq, st, we;
      logic [2:0] ra, wa;
      r  = ($urandom_range(0, 99) == 0);
      rq = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 3) == 0);
      we = ($urandom_range(0, 2) == 0);
      ra = 3'($urandom_range(0, 7));
      wa = 3'($urandom_range(0, 7));
      cyc(r, rq, ra, st, we, wa, $urandom);
    end

    // Reset mid-stream during back-to-back reads; written word reverts.
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 3'd3, 32'hA5A5_5A5A);
    cyc(0, 1, 3'd3, 0, 0, 0, 0);
    cyc(0, 1, 3'd3, 0, 0, 0, 0);
    cyc(1, 1, 3'd3, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 1, 3'd3, 0, 0, 0, 0);
    cyc(0, 1, 3'd3, 0, 0, 0, 0);
    check("reverted_word", 0, rd_data[0], boot(3));
    cyc(0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_param.md
Name: instr_mem_param

Overview:
- Parametrised instruction memory for the single-cycle/multi-cycle core. Successor to the fixed 5-word reset-loaded instruction store.
- Adds:
  - configurable width and depth
  - a hardware init sequencer that clears every word after reset
  - a registered read port with req/stall handshake
  - a loader write port
  - out-of-range error reporting
- Sits between the PC/fetch stage (read side) and the program loader (write side).

Parameters:
- DATA_W, 32, instruction word width in bits (>= 32 when IMEM_BOOT_PRELOAD_EN is defined).
- DEPTH, 8, number of words (any value >= 5).
- ADDR_W, $clog2(DEPTH) (minimum 1), address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- init_busy  out  1  high while the init sequencer runs.
- rd_req  in  1  fetch request.
- rd_addr  in  ADDR_W  fetch word address.
- rd_ready  out  1  request accepted this cycle if rd_req=1.
- rd_stall  in  1  consumer cannot take rd_data this cycle.
- rd_valid  out  1  rd_data/rd_err valid.
- rd_data  out  DATA_W  fetched instruction.
- rd_err  out  1  fetched address was >= DEPTH.
- wr_en  in  1  loader write strobe.
- wr_addr  in  ADDR_W  loader write address.
- wr_data  in  DATA_W  loader write data.
- wr_drop  out  1  pulse: write was discarded (during init, or address out of range).

Behaviour:
- Reset (rst=1 at an edge): state=INIT, init_ptr=0, rd_valid=0, rd_data=0, rd_err=0, wr_drop=0.
  - Memory contents are not touched in the reset cycle itself.
  - Reset asserted mid-operation: any in-flight read is aborted (rd_valid=0 next cycle), and the whole init sequence reruns.
- FSM states INIT and READY.
  - INIT:
    - init_busy=1, rd_ready=0.
    - Each cycle writes the init value to mem[init_ptr], then init_ptr++.
    - When init_ptr==DEPTH-1 is written, go to READY.
    - INIT lasts exactly DEPTH cycles after reset deasserts.
    - Init value is 0 for every word, unless IMEM_BOOT_PRELOAD_EN is defined.
  - READY: init_busy=0. READY only leaves on rst.
- Read handshake:
  - rd_ready = READY && !(rd_valid && rd_stall).
  - Accept: rd_req && rd_ready at edge N. At edge N+1, rd_valid=1 and rd_data=mem[rd_addr] (one-cycle latency, registered output).
  - Stall: if rd_valid && rd_stall, rd_valid/rd_data/rd_err hold unchanged, and rd_req is ignored (the requester holds it).
  - No accept and not stalled: rd_valid goes to 0 next edge. rd_data holds its last value (don't care).
  - Back-to-back accepts each cycle give continuous rd_valid=1.
- Out of range (rd_addr >= DEPTH, possible for non-power-of-2 DEPTH): rd_valid=1, rd_data=0, rd_err=1. Otherwise rd_err=0.
- Writes:
  - In READY with wr_en and wr_addr < DEPTH: mem[wr_addr]=wr_data at the edge.
  - wr_en during INIT, or with wr_addr >= DEPTH: write discarded, wr_drop=1 for one cycle.
- Read/write same address in the same cycle: read-first; rd_data returns the old word. The new word is visible to the next accepted read.
- Read and write to different addresses in the same cycle are fully independent.

Optional Feature:
- Macro: IMEM_BOOT_PRELOAD_EN.
- Defined: INIT writes a fixed boot program, zero-extended to DATA_W. All other words are written 0.
  - word0 = 0x00000000
  - word1 = 0x54410003
  - word2 = 0x51010001
  - word3 = 0x90640800
  - word4 = 0xB1480800
- INIT length is unchanged (DEPTH cycles).
- Undefined: all words are cleared to 0.

Test Plan:
- Reset sequencing: rst high 2 cycles then low (DEPTH=8) -> init_busy=1 for exactly 8 cycles, rd_ready=0 throughout; then init_busy=0. A read of every address returns 0, or the boot words when the macro is defined (e.g. addr3 -> 0x90640800).
- Write then read: write 0xDEADBEEF to addr 6, then rd_req addr 6 the next cycle -> rd_valid=1 one cycle after accept, rd_data=0xDEADBEEF, rd_err=0.
- Same-cycle collision: addr 2 holds 0x11111111; in one cycle, write 0x22222222 and read addr 2 -> read returns 0x11111111; the following read returns 0x22222222.
- Stall: accept a read of addr 1, then hold rd_stall=1 for 3 cycles while changing rd_addr -> rd_valid/rd_data frozen, rd_ready=0. Release the stall -> the next request is accepted.
- Out of range (DEPTH=6, ADDR_W=3): read addr 7 -> rd_valid=1, rd_data=0, rd_err=1. Write addr 6 -> wr_drop pulse, memory unchanged.
- Reset mid-stream: during back-to-back reads, assert rst 1 cycle -> rd_valid=0 next cycle, INIT reruns, and a previously written word reads back as 0 (or its boot value).
